product_bank_loader: RTL and testbench
======================================

Name: product_bank_loader

Overview:
- Producer side of the 32-input tree adder.
- Accepts a serial stream of signed pixel/weight pairs over a valid/ready handshake and multiplies each pair into a 36-bit signed product.
- Stores the products in a 32-slot bank and presents the whole bank as one flattened bus, with a valid/ready handshake, to the downstream adder.
- Supports short frames: an early `in_last` finishes the frame and the unused slots read as zero.

Parameters:
- `N`, 32, number of product slots (adder fan-in).
- `DW`, 16, signed pixel width.
- `WW`, 20, signed weight width.
- `PW`, 36, signed product width; must equal `DW+WW`.
- `CW`, 6, counter width; holds 0..`N`.

Ports:
- `clk`  in  1  clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `in_valid`  in  1  pair presented.
- `in_ready`  out  1  loader accepts a pair this cycle.
- `in_data`  in  `DW`  signed pixel.
- `in_weight`  in  `WW`  signed weight.
- `in_last`  in  1  final pair of the frame; qualified by `in_valid`.
- `out_valid`  out  1  bank complete and stable.
- `out_ready`  in  1  adder side consumed the bank.
- `prod_bus`  out  `N*PW`  slot k at `[k*PW +: PW]`; slot 0 feeds adder input 1.
- `fill_count`  out  `CW`  number of slots written in the current frame.

Behaviour:
- Reset (async, `rst_n`=0):
  - state=FILL, `fill_count`=0, all slots=0.
  - `in_ready`=1 after reset release; `out_valid`=0.
  - Reset mid-frame discards the partial bank; no `out_valid` pulse results.
- States:
  - FILL: `in_ready`=1, `out_valid`=0.
  - FULL: `in_ready`=0, `out_valid`=1.
- Input accept: `in_valid && in_ready` on a rising edge.
  - slot[`fill_count`] <= `$signed(in_data)*$signed(in_weight)`, full `PW`-bit result, no truncation or saturation.
  - `fill_count` increments.
- FILL->FULL transition, on the same accepting edge, when either:
  - the accepted pair has `in_last`=1, or
  - the accepted pair lands in slot `N-1`.
- `in_last` on slot `N-1`: single transition, identical to a full frame.
- `in_last` on slot k<`N-1`: slots k+1..`N-1` keep 0, since they were cleared at the previous drain.
- Latency: the final pair accepted at edge t gives `out_valid`=1 after edge t; `prod_bus` is valid in the same cycle.
- FULL hold: `prod_bus` and `fill_count` stay constant while `out_valid && !out_ready`. Input is ignored (`in_ready`=0), so no overwrite is possible.
- Drain: `out_valid && out_ready` at edge u:
  - all slots <= 0, `fill_count` <= 0, state <= FILL.
  - `in_ready`=1 from the cycle after edge u; one bubble between frames.
- `out_ready` asserted during FILL has no effect.
- `in_valid` low during FILL holds all state; gaps are allowed anywhere in a frame.
- `in_data`, `in_weight` and `in_last` are don't-care when `in_valid`=0.
- `fill_count` never exceeds `N`; there is no wrap-around.
- No combinational path from `in_*` to `out_*`; `in_ready` and `out_valid` decode from the state register only.

Decomposition:
- Shared package `adder_tree_pkg` holds:
  - constants `N_ADD`=32, `PROD_W`=36, `PIX_W`=16, `WGT_W`=20;
  - localparams for states FILL and FULL;
  - the result slice constants `RES_MSB`=27 and `RES_LSB`=12, consumed downstream.
- One natural sub-module, `signed_mult`: a combinational `DW`x`WW` to `PW` signed multiplier, so a pipelined or DesignWare variant can be swapped in later.
- Slot storage and control stay in `product_bank_loader`.

Test Plan:
- Full frame:
  - Stimulus: 32 back-to-back pairs, data=k+1, weight=2, no `in_last`.
  - Required: `out_valid` rises 1 cycle after the 32nd accept; slot k = 2(k+1); `fill_count`=32; their sum 1056 is checked at the adder.
- Sign extremes:
  - Stimulus: pair (-32768, -524288), then (-32768, 524287), then `in_last`.
  - Required: slot0 = 0x4_0000_0000 (+2^34); slot1 = -17179836416 sign-extended across 36 bits; slots 2..31 = 0; `fill_count`=2.
- Short frame:
  - Stimulus: 5 pairs (3,-4) with `in_last` on the 5th.
  - Required: `out_valid` one cycle later; slots 0..4 = -12; slots 5..31 = 0; `fill_count`=5.
- Backpressure:
  - Stimulus: hold `out_ready`=0 for 10 cycles after FULL while driving `in_valid`=1 with new data.
  - Required: `in_ready`=0, bus unchanged; after the `out_ready` pulse, the bank reads 0 and `in_ready`=1 on the next cycle.
- Gapped input:
  - Stimulus: toggle `in_valid` every other cycle for 32 pairs.
  - Required: same bank as the gap-free run; `out_valid` asserts only after the 32nd accept.
- Reset mid-frame:
  - Stimulus: assert `rst_n`=0 asynchronously after 17 accepts, release, then send a 3-pair `in_last` frame.
  - Required: immediately on reset, `fill_count`=0 and all slots 0; the next bank shows only the 3 new products.

Source files
------------

// File: rtl/adder_tree_pkg.sv
// rtl/adder_tree_pkg.sv - shared constants for the product bank loader and tree adder
package adder_tree_pkg;

  // Adder fan-in and operand/product widths
  localparam int N_ADD  = 32;
  localparam int PROD_W = 36;
  localparam int PIX_W  = 16;
  localparam int WGT_W  = 20;

  // Loader FSM encoding
  localparam logic [0:0] ST_FILL = 1'b0;
  localparam logic [0:0] ST_FULL = 1'b1;

  // Slice of the adder tree sum taken as the final result downstream
  localparam int RES_MSB = 27;
  localparam int RES_LSB = 12;

endpackage

// File: rtl/signed_mult.sv
// rtl/signed_mult.sv - combinational signed multiplier, full-width product
module signed_mult #(
  parameter int DW = 16,
  parameter int WW = 20,
  parameter int PW = 36
) (
  input  logic signed [DW-1:0] a_i,
  input  logic signed [WW-1:0] b_i,
  output logic signed [PW-1:0] prod_o
);

  // Sign-extend both operands to the product width so the low PW bits are exact
  logic signed [PW-1:0] a_ext;
  logic signed [PW-1:0] b_ext;

  assign a_ext  = PW'(a_i);
  assign b_ext  = PW'(b_i);
  assign prod_o = a_ext * b_ext;

endmodule

// File: rtl/product_bank_loader.sv
// rtl/product_bank_loader.sv - serial pixel/weight multiplier feeding a 32-slot product bank
module product_bank_loader
  import adder_tree_pkg::*;
#(
  parameter int N  = N_ADD,
  parameter int DW = PIX_W,
  parameter int WW = WGT_W,
  parameter int PW = PROD_W,
  parameter int CW = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [DW-1:0]   in_data,
  input  logic [WW-1:0]   in_weight,
  input  logic            in_last,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [N*PW-1:0] prod_bus,
  output logic [CW-1:0]   fill_count
);

  logic [0:0]    state_q, state_d;
  logic [CW-1:0] fill_q, fill_d;
  logic [PW-1:0] slot_q [N];
  logic [PW-1:0] prod;
  logic          accept;
  logic          drain;
  logic          last_slot;

  // Handshake outputs decode from the state register only
  assign in_ready   = (state_q == ST_FILL);
  assign out_valid  = (state_q == ST_FULL);
  assign accept     = in_valid && in_ready;
  assign drain      = out_valid && out_ready;
  assign last_slot  = (fill_q == CW'(N - 1));
  assign fill_count = fill_q;

  signed_mult #(
    .DW(DW),
    .WW(WW),
    .PW(PW)
  ) u_mult (
    .a_i   (in_data),
    .b_i   (in_weight),
    .prod_o(prod)
  );

  // Next state: close the frame on in_last or on the final slot, reopen on drain
  always_comb begin
    state_d = state_q;
    fill_d  = fill_q;
    case (state_q)
      ST_FILL: begin
        if (accept) begin
          fill_d = fill_q + CW'(1);
          if (in_last || last_slot) begin
            state_d = ST_FULL;
          end
        end
      end
      ST_FULL: begin
        if (out_ready) begin
          state_d = ST_FILL;
          fill_d  = '0;
        end
      end
      default: begin
        state_d = ST_FILL;
        fill_d  = '0;
      end
    endcase
  end

  // State and fill counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_FILL;
      fill_q  <= '0;
    end else begin
      state_q <= state_d;
      fill_q  <= fill_d;
    end
  end

  // Slot storage: cleared on drain so unused slots of a short frame read zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < N; k++) begin
        slot_q[k] <= '0;
      end
    end else if (drain) begin
      for (int k = 0; k < N; k++) begin
        slot_q[k] <= '0;
      end
    end else if (accept) begin
      for (int k = 0; k < N; k++) begin
        if (fill_q == CW'(k)) begin
          slot_q[k] <= prod;
        end
      end
    end
  end

  // Flatten the bank; slot 0 occupies the least significant bits
  for (genvar g = 0; g < N; g++) begin : g_bus
    assign prod_bus[g*PW +: PW] = slot_q[g];
  end

endmodule

// File: tb/tb_product_bank_loader.sv
// tb/tb_product_bank_loader.sv - scoreboard bench for product_bank_loader
module tb_product_bank_loader;

  localparam int N  = 32;
  localparam int DW = 16;
  localparam int WW = 20;
  localparam int PW = 36;
  localparam int CW = 6;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic [DW-1:0]   in_data;
  logic [WW-1:0]   in_weight;
  logic            in_last;
  logic            out_valid;
  logic            out_ready;
  logic [N*PW-1:0] prod_bus;
  logic [CW-1:0]   fill_count;

  typedef struct packed {
    logic [N*PW-1:0] bus;
    logic [CW-1:0]   fill;
  } exp_t;

  exp_t            sb_q[$];
  int              checks = 0;
  int              errors = 0;
  logic [N*PW-1:0] exp_bus;

  always #5 clk = ~clk;

  product_bank_loader dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_weight (in_weight),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .prod_bus  (prod_bus),
    .fill_count(fill_count)
  );

  task automatic check64(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic check_bus(input string name, input logic [N*PW-1:0] act, input logic [N*PW-1:0] req);
    int first;
    first = -1;
    checks++;
    for (int k = 0; k < N; k++) begin
      if (first < 0 && act[k*PW +: PW] !== req[k*PW +: PW]) first = k;
    end
    if (first >= 0) begin
      errors++;
      $display("FAIL %s: slot %0d got %0h expected %0h", name, first,
               act[first*PW +: PW], req[first*PW +: PW]);
    end
  endtask

  task automatic put(input int k, input logic signed [PW-1:0] v);
    exp_bus[k*PW +: PW] = v;
  endtask

  task automatic push(input int fill);
    sb_q.push_back('{bus: exp_bus, fill: CW'(fill)});
  endtask

  task automatic send(input logic signed [DW-1:0] d, input logic signed [WW-1:0] w,
                      input logic l, input logic exp_full);
    int n;
    n = 0;
    in_valid  = 1'b1;
    in_data   = d;
    in_weight = w;
    in_last   = l;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) check64("send_timeout", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    in_data   = DW'($urandom);
    in_weight = WW'($urandom);
    check64("out_valid_after_accept", 64'(out_valid), 64'(exp_full));
  endtask

  task automatic drain(input int hold, input logic junk);
    for (int i = 0; i < hold; i++) begin
      in_valid  = junk;
      in_data   = DW'($urandom);
      in_weight = WW'($urandom);
      in_last   = 1'($urandom);
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check64("out_valid_after_drain", 64'(out_valid), 64'd0);
    check64("in_ready_after_drain", 64'(in_ready), 64'd1);
    check_bus("bank_cleared", prod_bus, '0);
    check64("fill_after_drain", 64'(fill_count), 64'd0);
  endtask

  // Monitor: compare the presented bank every cycle it is valid, retire it on drain
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && out_valid === 1'b1) begin
        if (sb_q.size() == 0) begin
          check64("out_valid_unexpected", 64'(out_valid), 64'd0);
        end else begin
          check_bus("bank", prod_bus, sb_q[0].bus);
          check64("fill_count", 64'(fill_count), 64'(sb_q[0].fill));
          check64("in_ready_while_full", 64'(in_ready), 64'd0);
          if (out_ready) void'(sb_q.pop_front());
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    longint sum;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    in_data   = '0;
    in_weight = '0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_bus("reset_bank", prod_bus, '0);
    check64("reset_fill", 64'(fill_count), 64'd0);
    check64("reset_out_valid", 64'(out_valid), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check64("in_ready_after_reset", 64'(in_ready), 64'd1);

    // Full frame: data k+1, weight 2
    exp_bus = '0;
    for (int k = 0; k < N; k++) put(k, PW'(2 * (k + 1)));
    push(32);
    for (int k = 0; k < N; k++) send(DW'(k + 1), WW'(2), 1'b0, k == N - 1);
    sum = 0;
    for (int k = 0; k < N; k++) sum += $signed(prod_bus[k*PW +: PW]);
    check64("adder_sum", 64'(sum), 64'd1056);
    drain(0, 1'b0);

    // Sign extremes
    exp_bus = '0;
    put(0, 36'h4_0000_0000);
    put(1, -36'sd17179836416);
    push(2);
    send(16'h8000, 20'h80000, 1'b0, 1'b0);
    send(16'h8000, 20'h7FFFF, 1'b1, 1'b1);
    drain(1, 1'b0);

    // Short frame: five (3,-4) pairs
    exp_bus = '0;
    for (int k = 0; k < 5; k++) put(k, -36'sd12);
    push(5);
    for (int k = 0; k < 5; k++) send(16'sd3, -20'sd4, k == 4, k == 4);
    drain(0, 1'b0);

    // Backpressure: hold the bank 10 cycles while new pairs are offered
    exp_bus = '0;
    for (int k = 0; k < 4; k++) put(k, -36'sd63);
    push(4);
    for (int k = 0; k < 4; k++) send(16'sd7, -20'sd9, k == 3, k == 3);
    drain(10, 1'b1);

    // Gapped input: one idle cycle between pairs
    exp_bus = '0;
    for (int k = 0; k < N; k++) put(k, PW'(2 * (k + 1)));
    push(32);
    for (int k = 0; k < N; k++) begin
      send(DW'(k + 1), WW'(2), 1'b0, k == N - 1);
      if (k != N - 1) begin
        @(posedge clk); #1;
      end
    end
    drain(2, 1'b0);

    // Reset mid-frame after 17 accepts
    for (int k = 0; k < 17; k++) send(DW'(k + 5), -20'sd3, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check64("midreset_fill", 64'(fill_count), 64'd0);
    check_bus("midreset_bank", prod_bus, '0);
    check64("midreset_out_valid", 64'(out_valid), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    exp_bus = '0;
    put(0, 36'sd20000);
    put(1, -36'sd350);
    put(2, -36'sd1);
    push(3);
    send(16'sd100, 20'sd200, 1'b0, 1'b0);
    send(-16'sd50, 20'sd7, 1'b0, 1'b0);
    send(16'sd1, -20'sd1, 1'b1, 1'b1);
    drain(3, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    check64("scoreboard_empty", 64'(sb_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
